fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_perf_counter.sv | 35 +++
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               FSM state encoding, default widths, bubble encoding and the
//               width of the optional performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int          c_pc_w      = 10;
   localparam int          c_instr_w   = 32;
   localparam logic [31:0] c_nop_instr = 32'h0000_0000;
   localparam int          c_perf_w    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_perf_counter.sv
// ============================================================================
// Module      : fetch_perf_counter
// Description : Saturating event counter; sticks at all-ones.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset (count -> 0)
//               i_inc   - count one event this cycle
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_perf_counter
   import fetch_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_inc,
   output logic [c_perf_w-1:0] o_count
);

   logic [c_perf_w-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, issues word reads over
//               a req/valid handshake, presents registered fInstruction/fPC
//               to the FD register, inserts NOP bubbles while memory is busy,
//               skids one instruction under Stall and flushes the wrong path
//               on a taken branch.
// Ports       : clk, rst            - clock, async active-high reset
//               Stall               - downstream hold
//               BranchTaken/Target  - single-cycle redirect
//               imem_req/addr       - read request (combinational from state)
//               imem_rdata/valid    - read response
//               fInstruction/fPC    - registered output to FD register
//               FetchCount/BubbleCount - only with FETCH_PERF_EN defined
// Config      : FETCH_PERF_EN adds saturating fetch/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                 PC_W      = c_pc_w,
   parameter int                 INSTR_W   = c_instr_w,
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(c_nop_instr)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               Stall,
   input  logic               BranchTaken,
   input  logic [PC_W-1:0]    BranchTarget,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [INSTR_W-1:0] fInstruction,
   output logic [PC_W-1:0]    fPC
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        FetchCount,
   output logic [15:0]        BubbleCount
`endif
);

   fetch_state_t        r_state;
   fetch_state_t        w_next_state;
   logic [PC_W-1:0]     r_pc;
   logic [PC_W-1:0]     r_drain_addr;   // address of the request abandoned by a redirect
   logic [INSTR_W-1:0]  r_instr;
   logic [PC_W-1:0]     r_fpc;
   logic [INSTR_W-1:0]  r_skid_instr;
   logic [PC_W-1:0]     r_skid_pc;
   logic [PC_W-1:0]     w_pc_inc;

   assign w_pc_inc = r_pc + 1'b1;   // wraps modulo 2^PC_W

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic; a redirect overrides every other transition
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      if (BranchTaken) begin
         case (r_state)
            // An unanswered request must still complete before a new
            // address may be presented, so drain it first.
            REQ:     w_next_state = imem_valid ? REQ : DRAIN;
            DRAIN:   w_next_state = DRAIN;
            default: w_next_state = REQ;
         endcase
      end else begin
         case (r_state)
            IDLE:    w_next_state = REQ;
            REQ:     if (imem_valid && Stall) w_next_state = HOLD;
            HOLD:    if (!Stall) w_next_state = REQ;
            DRAIN:   if (imem_valid) w_next_state = REQ;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output logic (memory interface)
   // ------------------------------------------------------------------
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = r_pc;
      case (r_state)
         REQ: begin
            imem_req  = 1'b1;
            imem_addr = r_pc;
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = r_drain_addr;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = r_pc;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // PC, output register and skid buffer. HOLD is the only state with a
   // full skid, so no separate occupancy flag is kept.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_drain_addr <= '0;
         r_instr      <= NOP_INSTR;
         r_fpc        <= '0;
         r_skid_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
      end else if (BranchTaken) begin
         r_pc    <= BranchTarget;
         r_instr <= NOP_INSTR;
         r_fpc   <= BranchTarget;
         // In DRAIN the originally abandoned address is still outstanding.
         if (r_state == REQ) begin
            r_drain_addr <= r_pc;
         end
      end else begin
         case (r_state)
            REQ: begin
               if (imem_valid) begin
                  r_pc <= w_pc_inc;
                  if (Stall) begin
                     r_skid_instr <= imem_rdata;
                     r_skid_pc    <= r_pc;
                  end else begin
                     r_instr <= imem_rdata;
                     r_fpc   <= r_pc;
                  end
               end else if (!Stall) begin
                  r_instr <= NOP_INSTR;
                  r_fpc   <= r_pc;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  r_instr <= r_skid_instr;
                  r_fpc   <= r_skid_pc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fInstruction = r_instr;
   assign fPC          = r_fpc;

`ifdef FETCH_PERF_EN
   logic w_fetch_inc;
   logic w_bubble_inc;

   assign w_fetch_inc  = (r_state == REQ) && imem_valid && !BranchTaken;
   assign w_bubble_inc = (r_state == REQ) && !imem_valid && !Stall && !BranchTaken;

   fetch_perf_counter u_fetch_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_fetch_inc),
      .o_count (FetchCount)
   );

   fetch_perf_counter u_bubble_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_bubble_inc),
      .o_count (BubbleCount)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Memory returns
//               addr+0x100 after a programmable latency. Directed table and
//               hand sequences cover reset, zero-wait streaming, stall/skid,
//               2-cycle latency, redirect drain, PC wrap and reset mid-HOLD;
//               a randomized phase checks the delivered instruction stream
//               against an in-order address model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        Stall;
   logic        BranchTaken;
   logic [9:0]  BranchTarget;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] fInstruction;
   logic [9:0]  fPC;
`ifdef FETCH_PERF_EN
   logic [15:0] FetchCount;
   logic [15:0] BubbleCount;
`endif

   fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .Stall        (Stall),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_valid   (imem_valid),
      .fInstruction (fInstruction),
      .fPC          (fPC)
`ifdef FETCH_PERF_EN
      ,
      .FetchCount   (FetchCount),
      .BubbleCount  (BubbleCount)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   int wait_cnt  = 0;
   int fix_lat   = 0;
   int rnd_lat   = 0;
   bit rand_mode = 1'b0;
   int mem_lat;

   assign mem_lat    = rand_mode ? rnd_lat : fix_lat;
   assign imem_valid = imem_req && (wait_cnt == mem_lat);
   assign imem_rdata = imem_valid ? ({22'b0, imem_addr} + 32'h100) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (!imem_req || imem_valid) wait_cnt <= 0;
      else                         wait_cnt <= wait_cnt + 1;
      if (imem_valid) rnd_lat <= int'($urandom_range(0, 3));
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic [31:0] instr, input logic [9:0] pc);
      chk({name, "_instr"}, fInstruction, instr);
      chk({name, "_fpc"}, {22'b0, fPC}, {22'b0, pc});
   endtask

   typedef struct {
      logic        stall;
      logic        req;
      logic [9:0]  addr;
      logic [9:0]  fpc;
      logic [31:0] instr;
   } vec_t;

   vec_t tbl[11];

   // random-phase model state
   logic [9:0]  exp_pc;
   logic [31:0] last_instr;
   logic [9:0]  last_fpc;
   logic        pre_req, pre_valid, st, br;
   logic [9:0]  pre_addr, tgt;
   int          idle;
`ifdef FETCH_PERF_EN
   logic [15:0] snap_b, snap_f;
`endif

   initial begin
      // per cycle: Stall applied before the edge, expected values after it
      tbl[0]  = '{1'b0, 1'b1, 10'd0, 10'd0, 32'h000};
      tbl[1]  = '{1'b0, 1'b1, 10'd1, 10'd0, 32'h100};
      tbl[2]  = '{1'b0, 1'b1, 10'd2, 10'd1, 32'h101};
      tbl[3]  = '{1'b0, 1'b1, 10'd3, 10'd2, 32'h102};
      tbl[4]  = '{1'b0, 1'b1, 10'd4, 10'd3, 32'h103};
      tbl[5]  = '{1'b0, 1'b1, 10'd5, 10'd4, 32'h104};
      tbl[6]  = '{1'b1, 1'b0, 10'd0, 10'd4, 32'h104};
      tbl[7]  = '{1'b1, 1'b0, 10'd0, 10'd4, 32'h104};
      tbl[8]  = '{1'b1, 1'b0, 10'd0, 10'd4, 32'h104};
      tbl[9]  = '{1'b0, 1'b1, 10'd6, 10'd5, 32'h105};
      tbl[10] = '{1'b0, 1'b1, 10'd7, 10'd6, 32'h106};

      rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
      repeat (2) tick();
      chk_out("reset", NOP, 10'd0);
      chk("reset_req", {31'b0, imem_req}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_req", {31'b0, imem_req}, 32'd0);

      // zero-wait streaming then a 3-cycle stall over the addr-5 response
      for (int i = 0; i < 11; i++) begin
         Stall = tbl[i].stall;
         tick();
         chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
         if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), {22'b0, imem_addr}, {22'b0, tbl[i].addr});
         chk_out($sformatf("tbl%0d", i), tbl[i].instr, tbl[i].fpc);
      end

      // 2-cycle latency; redirect to 0x200 while addr 7 is outstanding
      Stall = 1'b0;
      fix_lat = 2;
      tick();
      chk_out("lat2_bubble7", NOP, 10'd7);
      BranchTaken = 1'b1; BranchTarget = 10'h200;
      tick();
      BranchTaken = 1'b0;
      chk_out("redir", NOP, 10'h200);
      chk("redir_req", {31'b0, imem_req}, 32'd1);
      chk("redir_drain_addr", {22'b0, imem_addr}, 32'd7);
      tick();
      chk("drained_addr", {22'b0, imem_addr}, 32'h200);
      chk_out("drained", NOP, 10'h200);
      for (int a = 10'h200; a < 10'h202; a++) begin
`ifdef FETCH_PERF_EN
         snap_b = BubbleCount; snap_f = FetchCount;
`endif
         repeat (2) begin
            tick();
            chk_out("lat2_bubble", NOP, 10'(a));
         end
         tick();
         chk_out("lat2_instr", 32'(a) + 32'h100, 10'(a));
`ifdef FETCH_PERF_EN
         chk("perf_bubbles", {16'b0, BubbleCount - snap_b}, 32'd2);
         chk("perf_fetches", {16'b0, FetchCount - snap_f}, 32'd1);
`endif
      end

      // PC wrap 0x3FF -> 0x000 with zero-wait memory
      fix_lat = 0;
      BranchTaken = 1'b1; BranchTarget = 10'h3FF;
      tick();
      BranchTaken = 1'b0;
      chk_out("wrap_redir", NOP, 10'h3FF);
      tick();
      chk_out("wrap_3ff", 32'h4FF, 10'h3FF);
      tick();
      chk_out("wrap_000", 32'h100, 10'h000);
      for (int a = 1; a < 5; a++) begin
         tick();
         chk_out("post_wrap", 32'(a) + 32'h100, 10'(a));
      end

      // skid addr 5, then asynchronous reset in the middle of HOLD
      Stall = 1'b1;
      tick();
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk_out("hold", 32'h104, 10'd4);
      #2 rst = 1'b1;
      #1;
      chk_out("async_rst", NOP, 10'd0);
      chk("async_rst_req", {31'b0, imem_req}, 32'd0);
      Stall = 1'b0;
      tick();
      rst = 1'b0;
      chk("restart_idle_req", {31'b0, imem_req}, 32'd0);
      tick();
      chk("restart_req", {31'b0, imem_req}, 32'd1);
      chk("restart_addr", {22'b0, imem_addr}, 32'd0);
      tick();
      chk_out("restart0", 32'h100, 10'd0);
      tick();
      chk_out("restart1", 32'h101, 10'd1);

      // randomized: stream must be in-order, complete, held under Stall
      exp_pc = 10'd2; last_instr = 32'h101; last_fpc = 10'd1; idle = 0;
      rand_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         st  = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 24) == 0);
         tgt = 10'($urandom);
         Stall = st; BranchTaken = br; BranchTarget = tgt;
         pre_req = imem_req; pre_valid = imem_valid; pre_addr = imem_addr;
         tick();
         if (pre_req && !pre_valid)
            chk("rnd_addr_stable", {21'b0, imem_req, imem_addr}, {21'b0, 1'b1, pre_addr});
         if (br) begin
            chk_out("rnd_redir", NOP, tgt);
            exp_pc = tgt;
            idle = 0;
         end else if (st) begin
            chk_out("rnd_hold", last_instr, last_fpc);
         end else if (fInstruction == NOP) begin
            chk("rnd_bubble_fpc", {22'b0, fPC}, {22'b0, exp_pc});
            idle++;
         end else begin
            chk_out("rnd_instr", {22'b0, exp_pc} + 32'h100, exp_pc);
            exp_pc = exp_pc + 1'b1;
            idle = 0;
         end
         if (idle > 60) begin
            chk("rnd_progress_timeout", idle, 0);
            idle = 0;
         end
         last_instr = fInstruction; last_fpc = fPC;
      end
      Stall = 1'b0; BranchTaken = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
